regwatch_checker: RTL and testbench
===================================

# regwatch_checker

Parametrised, self-checking register-watch block for the SoC instruction-test benches. It snoops the CPU core's register-file write port and holds a table of NUM_CHECKS expectations (register, value, cycle deadline). After `start` it counts cycles and judges each check at its deadline. It then reports an aggregate pass/fail with the first failing slot and the observed value. It replaces hand-written fixed-delay hierarchical peeks in per-instruction benches.

## Interface
- `XLEN`, 32: register/data width.
- `NUM_CHECKS`, 4: number of check slots (1..16).
- `CNT_W`, 16: cycle-counter and deadline width.
- `IDX_W`, $clog2(NUM_CHECKS) (min 1): slot index width.
- `clk`  in  1  system clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  write check slot `cfg_idx` (honoured only in IDLE).
- `cfg_idx`  in  IDX_W  slot being configured.
- `cfg_en`  in  1  slot enable.
- `cfg_reg`  in  5  watched register number (x0..x31).
- `cfg_expected`  in  XLEN  expected value.
- `cfg_deadline`  in  CNT_W  cycle count at which the slot is judged.
- `start`  in  1  begin a run (honoured in IDLE and DONE).
- `wb_en`  in  1  register-file write enable (snooped).
- `wb_addr`  in  5  register-file write address.
- `wb_data`  in  XLEN  register-file write data.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid when `done`: all enabled slots matched.
- `fail_idx`  out  IDX_W  lowest failing slot; 0 if pass.
- `fail_actual`  out  XLEN  observed value of `fail_idx`; 0 if pass.
- `cycle_count`  out  CNT_W  current run cycle counter.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `cfg_we` writes the slot entry. `start` moves to RUN and clears counter, shadows, per-slot resolved/failed flags, and the fail outputs.
- RUN: counter increments by 1 each cycle and saturates at 2^CNT_W-1.
- Each slot keeps a shadow XLEN value, cleared to 0 at start. Any `wb_en` with `wb_addr == slot reg` and `wb_addr != 0` loads `wb_data` into the shadow. x0 writes are ignored, so the x0 shadow is always 0.
- Judging happens when `counter == deadline` for an enabled, unresolved slot. The slot resolves with match = (shadow or same-cycle bypass) == expected.
- Same-cycle bypass: a qualifying write in the deadline cycle is included in the comparison.
- Disabled slots count as resolved and passing from start.
- RUN → DONE in the cycle after the last enabled slot resolves. With zero enabled slots, RUN lasts exactly one cycle.
- DONE outputs: `pass` = no slot failed. `fail_idx`/`fail_actual` = lowest-index failed slot and its compared value. Outputs hold until the next `start` or reset.
- DONE + `start` → RUN with the same table (rerun).
- `cfg_we` in RUN or DONE is ignored.
- `start` in RUN is ignored.
- Deadlines beyond the saturation value never resolve; the bench owns that timeout.

## Timing
- Reset (async assert, sync deassert in use): state IDLE; all outputs 0; table cleared (all `cfg_en`=0).
- Reset mid-run aborts with no result retained.
- `start` sampled at edge k → `busy`=1 from k; counter reads 0 in the first RUN cycle.
- A slot with deadline D is judged in the RUN cycle where `cycle_count`==D, i.e. D+1 cycles after the start edge.
- `done`=1 one edge after the final judgement. All outputs are registered.
- Config write at edge k is visible to a `start` sampled at edge k+1.

## Structure
- Package `regwatch_pkg`:
  - state enum {IDLE, RUN, DONE};
  - packed check-entry struct (en, reg, expected, deadline);
  - RUN cycle/result encodings.
- Sub-module `regwatch_slot`, one per slot via generate:
  - holds entry, shadow, resolved/failed flags;
  - inputs: snoop bus, counter, clear;
  - outputs: resolved, failed, compared value.
- Top holds the FSM, counter, priority encoder for lowest failing slot, and the all-resolved reduction.

## Test plan
- Sub test:
  - Config: slot0 = {x7, 0x00000005, D=7}.
  - Stimulus: start; write x7=0x5 at count 3.
  - Expect: `done` at count 8, `pass`=1.
- Fail:
  - Config: slot0 as above, slot2 = {x3, 0x10, D=4}; x3 written 0x11.
  - Expect: `pass`=0, `fail_idx`=2, `fail_actual`=0x11.
- Bypass:
  - Config: slot0 {x5, 0xA, D=6}.
  - Stimulus: x5=0x9 at count 2, x5=0xA at count 6.
  - Expect: pass. Then move the second write to count 7 → fail, `fail_actual`=0x9.
- x0 and empty:
  - Write x0=0xFF, check {x0, 0, D=2} → pass.
  - With all slots disabled: `start` → `done`,`pass`=1 two edges later.
- Reset/ignore:
  - Assert `reset_n`=0 at count 3 → all outputs 0, table cleared.
  - `cfg_we` during RUN leaves the entry unchanged on rerun.
- Rerun:
  - From DONE, pulse `start` → counter restarts at 0.
  - Shadows cleared; an unwritten register checked for 0x5 fails with `fail_actual`=0.

Source files
------------

// File: rtl/regwatch_pkg.sv
// Shared types for the register-watch checker.
//   state_e       : run-control FSM states
//   check_entry_t : one expectation slot (enable, register, value, deadline)
//   cnt_next()    : saturating run-cycle counter step
package regwatch_pkg;

  localparam int unsigned RW_XLEN  = 32;
  localparam int unsigned RW_CNT_W = 16;
  localparam int unsigned REG_W    = 5;

  // Register x0 is hardwired to zero; writes to it never reach a shadow.
  localparam logic [REG_W-1:0] REG_X0 = '0;

  // Result encoding: pass flag level as presented on the pass output.
  localparam logic RES_PASS = 1'b1;
  localparam logic RES_FAIL = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Entry widths follow the package widths; the top's XLEN/CNT_W default to them.
  typedef struct packed {
    logic                en;
    logic [REG_W-1:0]    rnum;
    logic [RW_XLEN-1:0]  expected;
    logic [RW_CNT_W-1:0] deadline;
  } check_entry_t;

  // Run-cycle counter: +1 per cycle, sticks at all-ones.
  function automatic logic [RW_CNT_W-1:0] cnt_next(input logic [RW_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + RW_CNT_W'(1);
  endfunction

endpackage

// File: rtl/regwatch_slot.sv
// One check slot: stored entry, shadow of the watched register, and the
// resolved/failed/compared-value state of the current run.
//   cfg_we/cfg_entry : entry write (already qualified by the top)
//   clear            : start of a run, resets shadow and verdict
//   run              : top is in RUN
//   wb_*             : snooped register-file write port
//   counter          : current run cycle
//   *_c outputs      : next-state values, so the top sees this cycle's verdict
module regwatch_slot
  import regwatch_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_we,
  input  check_entry_t        cfg_entry,
  input  logic                clear,
  input  logic                run,
  input  logic                wb_en,
  input  logic [REG_W-1:0]    wb_addr,
  input  logic [RW_XLEN-1:0]  wb_data,
  input  logic [RW_CNT_W-1:0] counter,
  output logic                resolved_c,
  output logic                failed_c,
  output logic [RW_XLEN-1:0]  actual_c
);

  check_entry_t       entry_q,    entry_d;
  logic [RW_XLEN-1:0] shadow_q,   shadow_d;
  logic               resolved_q, resolved_d;
  logic               failed_q,   failed_d;
  logic [RW_XLEN-1:0] actual_q,   actual_d;

  logic               hit;
  logic               judge;
  logic [RW_XLEN-1:0] cmp_val;

  // Shadow tracking and deadline judgement; a write in the deadline cycle bypasses the shadow.
  always_comb begin
    entry_d    = entry_q;
    shadow_d   = shadow_q;
    resolved_d = resolved_q;
    failed_d   = failed_q;
    actual_d   = actual_q;
    hit        = wb_en && (wb_addr == entry_q.rnum) && (wb_addr != REG_X0);
    cmp_val    = hit ? wb_data : shadow_q;
    judge      = run && entry_q.en && !resolved_q && (counter == entry_q.deadline);

    if (cfg_we) begin
      entry_d = cfg_entry;
    end

    if (clear) begin
      shadow_d   = '0;
      resolved_d = !entry_d.en;  // disabled slots are resolved and passing from the start
      failed_d   = 1'b0;
      actual_d   = '0;
    end else if (run) begin
      if (hit) begin
        shadow_d = wb_data;
      end
      if (judge) begin
        resolved_d = 1'b1;
        failed_d   = (cmp_val != entry_q.expected);
        actual_d   = cmp_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_q    <= '0;
      shadow_q   <= '0;
      resolved_q <= 1'b0;
      failed_q   <= 1'b0;
      actual_q   <= '0;
    end else begin
      entry_q    <= entry_d;
      shadow_q   <= shadow_d;
      resolved_q <= resolved_d;
      failed_q   <= failed_d;
      actual_q   <= actual_d;
    end
  end

  assign resolved_c = resolved_d;
  assign failed_c   = failed_d;
  assign actual_c   = actual_d;

endmodule

// File: rtl/regwatch_checker.sv
// Register-watch checker: snoops the register-file write port and judges a
// table of (register, value, deadline) expectations during a run.
//   cfg_*        : slot table write, accepted in IDLE only
//   start        : begin a run from IDLE or DONE
//   wb_*         : snooped register-file write port
//   busy/done    : in RUN / in DONE
//   pass         : all enabled slots matched (valid with done)
//   fail_idx     : lowest failing slot, fail_actual its compared value
//   cycle_count  : run cycle counter
module regwatch_checker
  import regwatch_pkg::*;
#(
  parameter int unsigned XLEN       = RW_XLEN,
  parameter int unsigned NUM_CHECKS = 4,
  parameter int unsigned CNT_W      = RW_CNT_W,
  parameter int unsigned IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [4:0]       cfg_reg,
  input  logic [XLEN-1:0]  cfg_expected,
  input  logic [CNT_W-1:0] cfg_deadline,
  input  logic             start,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] fail_idx,
  output logic [XLEN-1:0]  fail_actual,
  output logic [CNT_W-1:0] cycle_count
);

  state_e           state_q,       state_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic             busy_q,        busy_d;
  logic             done_q,        done_d;
  logic             pass_q,        pass_d;
  logic [IDX_W-1:0] fail_idx_q,    fail_idx_d;
  logic [XLEN-1:0]  fail_actual_q, fail_actual_d;

  logic                  run;
  logic                  clear;
  check_entry_t          cfg_entry;
  logic [NUM_CHECKS-1:0] cfg_sel;
  logic [NUM_CHECKS-1:0] resolved_c;
  logic [NUM_CHECKS-1:0] failed_c;
  logic [XLEN-1:0]       actual_c [NUM_CHECKS];
  logic                  fail_any;
  logic [IDX_W-1:0]      first_idx;
  logic [XLEN-1:0]       first_val;

  // Kept outside the FSM block so slot verdicts do not loop back through it.
  assign run   = (state_q == RUN);
  assign clear = start && (state_q != RUN);

  assign cfg_entry = '{en: cfg_en, rnum: cfg_reg, expected: cfg_expected,
                       deadline: cfg_deadline};

  for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_slot
    assign cfg_sel[i] = cfg_we && (state_q == IDLE) && (cfg_idx == IDX_W'(i));

    regwatch_slot u_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .cfg_we     (cfg_sel[i]),
      .cfg_entry  (cfg_entry),
      .clear      (clear),
      .run        (run),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .counter    (cnt_q),
      .resolved_c (resolved_c[i]),
      .failed_c   (failed_c[i]),
      .actual_c   (actual_c[i])
    );
  end

  // Lowest-index failing slot; scanning downward lets the lowest hit win.
  always_comb begin
    fail_any  = |failed_c;
    first_idx = '0;
    first_val = '0;
    for (int i = int'(NUM_CHECKS) - 1; i >= 0; i--) begin
      if (failed_c[i]) begin
        first_idx = IDX_W'(i);
        first_val = actual_c[i];
      end
    end
  end

  // Run-control FSM and registered result outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pass_d        = pass_q;
    fail_idx_d    = fail_idx_q;
    fail_actual_d = fail_actual_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = RUN;
          cnt_d         = '0;
          pass_d        = RES_FAIL;
          fail_idx_d    = '0;
          fail_actual_d = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_next(cnt_q);
        // resolved_c already includes this cycle's judgements
        if (&resolved_c) begin
          state_d       = DONE;
          pass_d        = fail_any ? RES_FAIL : RES_PASS;
          fail_idx_d    = first_idx;
          fail_actual_d = first_val;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_idx_q    <= '0;
      fail_actual_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_idx_q    <= fail_idx_d;
      fail_actual_q <= fail_actual_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_idx    = fail_idx_q;
  assign fail_actual = fail_actual_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_regwatch_checker.sv
// Directed bench for regwatch_checker: sub/fail/bypass/x0/empty/reset/rerun cases.
module tb_regwatch_checker;

  logic        clk;
  logic        reset_n;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic        cfg_en;
  logic [4:0]  cfg_reg;
  logic [31:0] cfg_expected;
  logic [15:0] cfg_deadline;
  logic        start;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  fail_idx;
  logic [31:0] fail_actual;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;

  regwatch_checker dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_en       (cfg_en),
    .cfg_reg      (cfg_reg),
    .cfg_expected (cfg_expected),
    .cfg_deadline (cfg_deadline),
    .start        (start),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_idx     (fail_idx),
    .fail_actual  (fail_actual),
    .cycle_count  (cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_pass"},  32'(pass), 32'd0);
    check({tag, "_fidx"},  32'(fail_idx), 32'd0);
    check({tag, "_fact"},  fail_actual, 32'd0);
    check({tag, "_count"}, 32'(cycle_count), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic cfg(input int idx, input logic en, input logic [4:0] r,
                     input logic [31:0] e, input logic [15:0] d);
    cfg_we       = 1'b1;
    cfg_idx      = 2'(idx);
    cfg_en       = en;
    cfg_reg      = r;
    cfg_expected = e;
    cfg_deadline = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic wait_count(input string tag, input int c);
    for (int n = 0; n < 200 && int'(cycle_count) != c; n++) tick();
    check({tag, "_reach_count"}, 32'(cycle_count), 32'(c));
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 200 && done !== 1'b1; n++) tick();
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic p, input logic [1:0] idx,
                              input logic [31:0] act, input logic [15:0] cnt);
    check({tag, "_pass"},  32'(pass), 32'(p));
    check({tag, "_fidx"},  32'(fail_idx), 32'(idx));
    check({tag, "_fact"},  fail_actual, act);
    check({tag, "_count"}, 32'(cycle_count), 32'(cnt));
    check({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    cfg_we       = 1'b0;
    cfg_idx      = '0;
    cfg_en       = 1'b0;
    cfg_reg      = '0;
    cfg_expected = '0;
    cfg_deadline = '0;
    start        = 1'b0;
    wb_en        = 1'b0;
    wb_addr      = '0;
    wb_data      = '0;

    // Reset state
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Sub: x7 = 5 at count 3, judged at D=7, done at count 8
    cfg(0, 1'b1, 5'd7, 32'h5, 16'd7);
    do_start();
    check("sub_busy0",  32'(busy), 32'd1);
    check("sub_count0", 32'(cycle_count), 32'd0);
    wait_count("sub_w", 3);
    wb_write(5'd7, 32'h5);
    wait_count("sub_pre", 7);
    check("sub_notdone7", 32'(done), 32'd0);
    wait_done("sub");
    check_result("sub", 1'b1, 2'd0, 32'h0, 16'd8);

    // Fail: slot2 x3 expects 0x10, sees 0x11
    do_reset();
    cfg(0, 1'b1, 5'd7, 32'h5, 16'd7);
    cfg(2, 1'b1, 5'd3, 32'h10, 16'd4);
    do_start();
    wait_count("fail_w3", 1);
    wb_write(5'd3, 32'h11);
    wait_count("fail_w7", 3);
    wb_write(5'd7, 32'h5);
    wait_done("fail");
    check_result("fail", 1'b0, 2'd2, 32'h11, 16'd8);

    // Bypass: write of the expected value in the deadline cycle counts
    do_reset();
    cfg(0, 1'b1, 5'd5, 32'hA, 16'd6);
    do_start();
    wait_count("byp_w2", 2);
    wb_write(5'd5, 32'h9);
    wait_count("byp_w6", 6);
    wb_write(5'd5, 32'hA);
    wait_done("byp");
    check_result("byp", 1'b1, 2'd0, 32'h0, 16'd7);

    // Rerun of the same table with the correcting write too late
    do_start();
    check("byp2_count0", 32'(cycle_count), 32'd0);
    check("byp2_busy",   32'(busy), 32'd1);
    wait_count("byp2_w2", 2);
    wb_write(5'd5, 32'h9);
    wait_done("byp2");
    check_result("byp2", 1'b0, 2'd0, 32'h9, 16'd7);

    // x0: writes ignored; slot1 expects 0 (pass), slot3 expects 0xFF (fails with 0)
    do_reset();
    cfg(1, 1'b1, 5'd0, 32'h0, 16'd2);
    cfg(3, 1'b1, 5'd0, 32'hFF, 16'd2);
    do_start();
    wait_count("x0_w1", 1);
    wb_write(5'd0, 32'hFF);
    wb_write(5'd0, 32'hFF);
    wait_done("x0");
    check_result("x0", 1'b0, 2'd3, 32'h0, 16'd3);

    // Empty table: one RUN cycle then DONE with pass
    do_reset();
    do_start();
    check("empty_busy", 32'(busy), 32'd1);
    check("empty_done0", 32'(done), 32'd0);
    tick();
    check("empty_done1", 32'(done), 32'd1);
    check_result("empty", 1'b1, 2'd0, 32'h0, 16'd1);

    // Reset mid-run aborts and clears the table
    do_reset();
    cfg(0, 1'b1, 5'd7, 32'h5, 16'd7);
    do_start();
    wait_count("rst_w", 3);
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    reset_n = 1'b1;
    tick();
    do_start();
    tick();
    check("rst_tblclr_done", 32'(done), 32'd1);
    check_result("rst_tblclr", 1'b1, 2'd0, 32'h0, 16'd1);

    // cfg_we in RUN ignored; start in RUN ignored
    do_reset();
    cfg(0, 1'b1, 5'd7, 32'h5, 16'd7);
    do_start();
    cfg(0, 1'b1, 5'd7, 32'h99, 16'd2);
    wait_count("ign_s", 2);
    do_start();
    check("ign_start_count", 32'(cycle_count), 32'd3);
    wb_write(5'd7, 32'h5);
    wait_done("ign");
    check_result("ign", 1'b1, 2'd0, 32'h0, 16'd8);
    do_start();
    wait_count("ign2_w", 3);
    wb_write(5'd7, 32'h5);
    wait_done("ign2");
    check_result("ign2", 1'b1, 2'd0, 32'h0, 16'd8);

    // Rerun clears shadows: unwritten x9 expected 5 fails with 0
    do_reset();
    cfg(0, 1'b1, 5'd9, 32'h5, 16'd3);
    do_start();
    wait_count("rr_w", 1);
    wb_write(5'd9, 32'h5);
    wait_done("rr1");
    check_result("rr1", 1'b1, 2'd0, 32'h0, 16'd4);
    do_start();
    check("rr2_count0", 32'(cycle_count), 32'd0);
    wait_done("rr2");
    check_result("rr2", 1'b0, 2'd0, 32'h0, 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
